// File: rtl/sample_serializer_pkg.sv
// sample_serializer_pkg: FSM state encoding and frame constants shared by the serializer files
package sample_serializer_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
  localparam int FRAME_BITS = 11;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample buffer, DEPTH a power of two
// ports: clk, rst_n (async active-low), i_flush (empties buffer, overrides push/pop),
//        i_push/i_din write, i_pop advances head, o_dout head word, o_full, o_empty
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  // pointers wrap naturally at DEPTH because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  always_ff @(posedge clk)
    if (i_push && !i_flush) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/sample_serializer.sv
// sample_serializer: buffers 8-bit samples and sends each as start/8 data LSB-first/even parity/stop
// ports: clk, rst_n (async active-low), enn (low flushes and idles), din/din_valid sample input,
//        ser_out serial line (idle 1), ser_busy, frame_start pulse, fifo_full, overflow pulse
module sample_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enn,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       ser_out,
  output logic       ser_busy,
  output logic       frame_start,
  output logic       fifo_full,
  output logic       overflow
);
  import sample_serializer_pkg::*;
  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic [2:0] r_idx, w_idx;
  logic [7:0] r_sh, w_sh;
  logic       r_par, w_par;
  logic       r_ser, r_fs, r_busy, r_ovf;
  logic       w_pop, w_push, w_empty, w_full, w_bit_end, w_ser;
  logic [7:0] w_head;
  // a pop frees a slot in the same cycle, so a strobe into a full buffer is still taken then
  assign w_push = enn && din_valid && (!w_full || w_pop);
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_flush(!enn),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (din),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  always_comb begin
    w_bit_end = r_cnt == 8'(CLKS_PER_BIT - 1);
    w_state   = r_state;
    w_cnt     = w_bit_end ? '0 : r_cnt + 8'd1;
    w_idx     = r_idx;
    w_sh      = r_sh;
    w_par     = r_par;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_state = S_START;
        end
      end
      S_START:
        if (w_bit_end) begin
          w_state = S_DATA;
          w_idx   = '0;
        end
      S_DATA:
        if (w_bit_end) begin
          w_sh  = r_sh >> 1;
          w_idx = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state = S_PARITY;
        end
      S_PARITY:
        if (w_bit_end) w_state = S_STOP;
      S_STOP:
        if (w_bit_end) begin
          w_pop   = !w_empty;
          w_state = w_empty ? S_IDLE : S_START;
        end
      default: w_state = S_IDLE;
    endcase
    if (!enn) begin
      w_state = S_IDLE;
      w_cnt   = '0;
      w_pop   = 1'b0;
    end
    if (w_pop) begin
      w_sh  = w_head;
      w_par = ^w_head;
    end
    w_ser = r_state == S_DATA ? r_sh[0] : r_state == S_PARITY ? r_par : r_state != S_START;
  end
  // line outputs are registered from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_ser   <= 1'b1;
      r_fs    <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_sh    <= w_sh;
      r_par   <= w_par;
      r_ser   <= !enn || w_ser;
      r_fs    <= enn && r_state == S_START && r_cnt == '0;
      r_busy  <= enn && (r_state != S_IDLE || !w_empty);
      r_ovf   <= enn && din_valid && w_full && !w_pop;
    end
  assign ser_out     = r_ser;
  assign ser_busy    = r_busy;
  assign frame_start = r_fs;
  assign fifo_full   = w_full;
  assign overflow    = r_ovf;
endmodule
